// File: rtl/pool_pkg.sv
// Shared definitions for the pooling datapath: mode constants and the
// width helper used to size counters and accumulators.
package pool_pkg;

   typedef enum logic [0:0] {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   localparam int WINDOW_MIN = 2;
   localparam int WINDOW_MAX = 256;

   // Ceiling log2, bounded loop so it stays a legal constant function.
   function automatic int pool_clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pool_stream_if.sv
// Element stream in, pooled result stream out, plus the window abort.
interface pool_stream_if #(
   parameter int DATA_W = 22
) ();
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output clear, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  clear, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pool_combine.sv
// Combinational reduction step: folds one element into the running
// accumulator (max or sum). Also exposes the element extended to the
// accumulator width so callers can load it on the first beat.
module pool_combine
   import pool_pkg::*;
#(
   parameter int         DATA_W = 22,
   parameter int         ACC_W  = 22,
   parameter pool_mode_e MODE   = POOL_MAX,
   parameter int         SIGNED = 1
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] elem,
   output logic [ACC_W-1:0]  elem_ext,
   output logic [ACC_W-1:0]  acc_next
);
   localparam int EXT_W = ACC_W + 1 - DATA_W;

   // One guard bit above the accumulator lets a single signed compare
   // serve both signed (sign-fill) and unsigned (zero-fill) builds.
   logic                    fill_acc;
   logic                    fill_elem;
   logic signed [ACC_W:0]   acc_x;
   logic signed [ACC_W:0]   elem_x;
   logic        [ACC_W-1:0] sum;

   assign fill_acc  = (SIGNED != 0) ? acc[ACC_W-1]   : 1'b0;
   assign fill_elem = (SIGNED != 0) ? elem[DATA_W-1] : 1'b0;
   assign acc_x     = {fill_acc, acc};
   assign elem_x    = {{EXT_W{fill_elem}}, elem};
   assign elem_ext  = elem_x[ACC_W-1:0];
   assign sum       = acc + elem_x[ACC_W-1:0];

   // Select the combine rule; on a max tie the accumulator is kept.
   always_comb begin
      acc_next = acc;
      if (MODE == POOL_AVG) begin
         acc_next = sum;
      end else if (elem_x > acc_x) begin
         acc_next = elem_x[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/pool_stream.sv
// Streaming pooling unit: reduces each WINDOW consecutive elements to
// their maximum or floor-mean, with a one-deep held output register.
// Only the closing beat of a window stalls while a result is unread.
module pool_stream
   import pool_pkg::*;
#(
   parameter int         DATA_W = 22,
   parameter int         WINDOW = 16,
   parameter pool_mode_e MODE   = POOL_MAX,
   parameter int         SIGNED = 1
) (
   input logic           clk,
   input logic           rst,
   pool_stream_if.slave  s
);
   localparam int LOG2W = pool_clog2(WINDOW);
   localparam int CNT_W = LOG2W;
   localparam int ACC_W = (MODE == POOL_AVG) ? DATA_W + LOG2W : DATA_W;

   generate
      if (WINDOW < WINDOW_MIN || WINDOW > WINDOW_MAX ||
          (MODE == POOL_AVG && (WINDOW & (WINDOW - 1)) != 0)) begin : g_bad_cfg
         $error("pool_stream: WINDOW must be 2..256 and a power of two for POOL_AVG");
      end
   endgenerate

   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  elem_ext;
   logic [ACC_W-1:0]  comb_next;
   logic [DATA_W-1:0] result;
   logic              first;
   logic              last;
   logic              accept;

   assign first      = (cnt == '0);
   assign last       = (cnt == CNT_W'(WINDOW - 1));
   assign s.in_ready = !s.clear && !(last && s.out_valid && !s.out_ready);
   assign accept     = s.in_valid && s.in_ready;

   pool_combine #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .MODE   (MODE),
      .SIGNED (SIGNED)
   ) u_combine (
      .acc      (acc),
      .elem     (s.in_data),
      .elem_ext (elem_ext),
      .acc_next (comb_next)
   );

   generate
      if (MODE == POOL_AVG) begin : g_avg
         // Floor divide by WINDOW: arithmetic and logical shifts differ only
         // in bits above DATA_W, which truncation drops, so a slice suffices.
         function automatic logic [DATA_W-1:0] avg_floor(input logic [ACC_W-1:0] total);
            return total[LOG2W +: DATA_W];
         endfunction
         assign result = avg_floor(comb_next);
      end else begin : g_max
         assign result = comb_next;
      end
   endgenerate

   // Window position and running accumulator; FIRST reloads, clear aborts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
      end else if (s.clear) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         cnt <= last ? '0 : cnt + 1'b1;
         acc <= first ? elem_ext : comb_next;
      end
   end

   // Held result: a new load wins over a same-cycle downstream accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s.out_valid <= 1'b0;
         s.out_data  <= '0;
      end else if (accept && last) begin
         s.out_valid <= 1'b1;
         s.out_data  <= result;
      end else if (s.out_ready) begin
         s.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pool_stream.sv
// Directed bench for pool_stream: signed max (W=16), signed avg (W=4)
// and unsigned avg (W=4) instances share one clock and reset.
module tb_pool_stream;
   import pool_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pool_stream_if #(.DATA_W(22)) bus_max ();
   pool_stream_if #(.DATA_W(22)) bus_avg ();
   pool_stream_if #(.DATA_W(22)) bus_avgu ();

   pool_stream #(.DATA_W(22), .WINDOW(16), .MODE(POOL_MAX), .SIGNED(1)) u_max (
      .clk (clk), .rst (rst), .s (bus_max)
   );
   pool_stream #(.DATA_W(22), .WINDOW(4), .MODE(POOL_AVG), .SIGNED(1)) u_avg (
      .clk (clk), .rst (rst), .s (bus_avg)
   );
   pool_stream #(.DATA_W(22), .WINDOW(4), .MODE(POOL_AVG), .SIGNED(0)) u_avgu (
      .clk (clk), .rst (rst), .s (bus_avgu)
   );

   task automatic beat_max(input logic [21:0] d);
      bus_max.in_valid = 1'b1;
      bus_max.in_data  = d;
      @(posedge clk); #1;
      bus_max.in_valid = 1'b0;
   endtask

   task automatic beat_avg(input logic [21:0] d);
      bus_avg.in_valid = 1'b1;
      bus_avg.in_data  = d;
      @(posedge clk); #1;
      bus_avg.in_valid = 1'b0;
   endtask

   task automatic beat_avgu(input logic [21:0] d);
      bus_avgu.in_valid = 1'b1;
      bus_avgu.in_data  = d;
      @(posedge clk); #1;
      bus_avgu.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus_max.clear = 1'b0;  bus_max.in_valid = 1'b0;  bus_max.in_data = '0;  bus_max.out_ready = 1'b1;
      bus_avg.clear = 1'b0;  bus_avg.in_valid = 1'b0;  bus_avg.in_data = '0;  bus_avg.out_ready = 1'b1;
      bus_avgu.clear = 1'b0; bus_avgu.in_valid = 1'b0; bus_avgu.in_data = '0; bus_avgu.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus_max.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus_max.out_valid); end
      checks++; if (bus_max.out_data !== 22'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 000000", bus_max.out_data); end
      rst = 1'b0;
      #1;
      checks++; if (bus_max.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus_max.in_ready); end
      checks++; if (bus_avg.out_valid !== 1'b0 || bus_avgu.out_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid: got %b/%b expected 0/0", bus_avg.out_valid, bus_avgu.out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_max_ramp;
      logic early;
      early = 1'b0;
      for (int i = 0; i < 15; i++) begin
         beat_max(22'(i));
         if (bus_max.out_valid !== 1'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL ramp_early_valid: got 1 expected 0 before beat 16"); end
      beat_max(22'd15);
      checks++; if (bus_max.out_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid: got %b expected 1", bus_max.out_valid); end
      checks++; if (bus_max.out_data !== 22'h00000F) begin errors++; $display("FAIL ramp_data: got %h expected 00000f", bus_max.out_data); end
      @(posedge clk); #1;
      checks++; if (bus_max.out_valid !== 1'b0) begin errors++; $display("FAIL ramp_consumed: got %b expected 0", bus_max.out_valid); end
   endtask

   task automatic test_max_negative;
      for (int i = 0; i < 15; i++) beat_max(22'h3FFFFF);
      beat_max(22'h3FFFFD);
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'h3FFFFF) begin errors++; $display("FAIL neg_max: got %b/%h expected 1/3fffff", bus_max.out_valid, bus_max.out_data); end
      // Back-to-back window of the most negative value: FIRST must reload.
      for (int i = 0; i < 16; i++) beat_max(22'h200000);
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'h200000) begin errors++; $display("FAIL neg_min_window: got %b/%h expected 1/200000", bus_max.out_valid, bus_max.out_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_avg;
      beat_avg(22'd3); beat_avg(22'd4); beat_avg(22'd5); beat_avg(22'h3FFFFF);
      checks++; if (bus_avg.out_valid !== 1'b1 || bus_avg.out_data !== 22'd2) begin errors++; $display("FAIL avg_pos: got %b/%h expected 1/000002", bus_avg.out_valid, bus_avg.out_data); end
      beat_avg(22'h3FFFFF); beat_avg(22'h3FFFFE); beat_avg(22'h3FFFFE); beat_avg(22'h3FFFFE);
      checks++; if (bus_avg.out_valid !== 1'b1 || bus_avg.out_data !== 22'h3FFFFE) begin errors++; $display("FAIL avg_floor_neg: got %b/%h expected 1/3ffffe", bus_avg.out_valid, bus_avg.out_data); end
      for (int i = 0; i < 4; i++) beat_avg(22'h200000);
      checks++; if (bus_avg.out_data !== 22'h200000) begin errors++; $display("FAIL avg_most_neg: got %h expected 200000", bus_avg.out_data); end
      for (int i = 0; i < 4; i++) beat_avgu(22'h3FFFFF);
      checks++; if (bus_avgu.out_valid !== 1'b1 || bus_avgu.out_data !== 22'h3FFFFF) begin errors++; $display("FAIL avg_unsigned_max: got %b/%h expected 1/3fffff", bus_avgu.out_valid, bus_avgu.out_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      logic all_ready;
      bus_max.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) beat_max(22'(2 * i));
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'd30) begin errors++; $display("FAIL bp_first_result: got %b/%h expected 1/00001e", bus_max.out_valid, bus_max.out_data); end
      all_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (bus_max.in_ready !== 1'b1) all_ready = 1'b0;
         beat_max(22'(100 + i));
      end
      checks++; if (!all_ready) begin errors++; $display("FAIL bp_accum_while_held: got in_ready 0 expected 1 on beats 1-15"); end
      bus_max.in_valid = 1'b1;
      bus_max.in_data  = 22'd115;
      #1;
      checks++; if (bus_max.in_ready !== 1'b0) begin errors++; $display("FAIL bp_last_stall: got %b expected 0", bus_max.in_ready); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'd30) begin errors++; $display("FAIL bp_held: got %b/%h expected 1/00001e", bus_max.out_valid, bus_max.out_data); end
      bus_max.out_ready = 1'b1;
      #1;
      checks++; if (bus_max.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b expected 1", bus_max.in_ready); end
      @(posedge clk); #1;
      bus_max.in_valid = 1'b0;
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'd115) begin errors++; $display("FAIL bp_swap: got %b/%h expected 1/000073", bus_max.out_valid, bus_max.out_data); end
      @(posedge clk); #1;
      checks++; if (bus_max.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus_max.out_valid); end
   endtask

   task automatic test_reset_mid;
      logic early;
      bus_max.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) beat_max(22'd7);
      for (int i = 0; i < 7; i++) beat_max(22'd1000);
      rst = 1'b1;
      #1;
      checks++; if (bus_max.out_valid !== 1'b0 || bus_max.out_data !== 22'h0) begin errors++; $display("FAIL rst_async: got %b/%h expected 0/000000", bus_max.out_valid, bus_max.out_data); end
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      bus_max.out_ready = 1'b1;
      early = 1'b0;
      for (int i = 0; i < 15; i++) begin
         beat_max(22'(i + 1));
         if (bus_max.out_valid !== 1'b0) early = 1'b1;
      end
      checks++; if (early) begin errors++; $display("FAIL rst_partial_kept: got early result expected none before beat 16"); end
      beat_max(22'd16);
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'd16) begin errors++; $display("FAIL rst_fresh_window: got %b/%h expected 1/000010", bus_max.out_valid, bus_max.out_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_clear;
      bus_max.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) beat_max(22'd5);
      for (int i = 0; i < 5; i++) beat_max(22'd500);
      bus_max.clear    = 1'b1;
      bus_max.in_valid = 1'b1;
      bus_max.in_data  = 22'd600;
      #1;
      checks++; if (bus_max.in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b expected 0", bus_max.in_ready); end
      @(posedge clk); #1;
      bus_max.clear    = 1'b0;
      bus_max.in_valid = 1'b0;
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'd5) begin errors++; $display("FAIL clear_held: got %b/%h expected 1/000005", bus_max.out_valid, bus_max.out_data); end
      bus_max.out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 11; i++) beat_max(22'(i + 1));
      checks++; if (bus_max.out_valid !== 1'b0) begin errors++; $display("FAIL clear_count: got %b expected 0 after 11 beats", bus_max.out_valid); end
      for (int i = 11; i < 16; i++) beat_max(22'(i + 1));
      checks++; if (bus_max.out_valid !== 1'b1 || bus_max.out_data !== 22'd16) begin errors++; $display("FAIL clear_window: got %b/%h expected 1/000010", bus_max.out_valid, bus_max.out_data); end
      @(posedge clk); #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset;
      test_max_ramp;
      test_max_negative;
      test_avg;
      test_backpressure;
      test_reset_mid;
      test_clear;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming, parametrised pooling unit for the CNN datapath. Consumes one feature-map element per cycle over a valid/ready handshake and reduces each group of `WINDOW` consecutive elements to one result, either the maximum or the arithmetic mean. It sits between the convolution output stream and the next layer's input buffer, and replaces fixed 16-input parallel max pooling with a back-pressured, width- and window-generic stream.

## Interface
- `DATA_W`, default 22: element and result width, two's complement when `SIGNED=1`.
- `WINDOW`, default 16: elements per pooling window. Legal range is 2..256. Must be a power of two when `MODE=POOL_AVG`.
- `MODE`, default `POOL_MAX`: `POOL_MAX` (0) selects maximum; `POOL_AVG` (1) selects mean.
- `SIGNED`, default 1: 1 means signed compare and arithmetic shift; 0 means unsigned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous abort of the partial window.
- `in_valid` in 1: upstream element valid.
- `in_ready` out 1: element accepted when `in_valid && in_ready`.
- `in_data` in `DATA_W`: element.
- `out_valid` out 1: result held valid until accepted.
- `out_ready` in 1: downstream accept.
- `out_data` out `DATA_W`: pooled result.

## Operation
- **State.**
  - Element counter `cnt`, width clog2(`WINDOW`), range 0..`WINDOW`-1.
  - Accumulator `acc`: `DATA_W` bits for max; `DATA_W`+clog2(`WINDOW`) bits, sign-extended when `SIGNED`, for avg.
  - One-deep output register with `out_valid`.
- **Phases, implied by `cnt`.**
  - FIRST (`cnt==0`): an accepted beat loads `acc` with the element, sign/zero-extended. No compare against stale data.
  - ACCUM (0<`cnt`<`WINDOW`-1): an accepted beat combines the element into `acc`. Max takes the larger value using the `SIGNED` rules; ties keep `acc`. Avg adds.
  - LAST (`cnt==WINDOW`-1): an accepted beat writes the final combine into `out_data`, sets `out_valid`, and wraps `cnt` to 0.
- **Avg result.** `(acc+element) >>> clog2(WINDOW)`, arithmetic shift for `SIGNED=1`, logical otherwise. The result rounds toward negative infinity, is truncated to `DATA_W`, and cannot overflow.
- **Output.** `out_valid` clears on an `out_valid && out_ready` cycle unless a new result loads in the same cycle. Simultaneous accept and load: the new result replaces the old one and `out_valid` stays 1.
- **`in_ready`.**
  - `in_ready = !clear && !(cnt==WINDOW-1 && out_valid && !out_ready)`.
  - Accumulation of the next window continues while a result is held. Only the LAST beat stalls.
- **`clear`.** Zeroes `cnt` and `acc` and forces `in_ready=0` that cycle, so a beat presented then is not consumed. It does not touch `out_valid` or `out_data`.
- **`rst`.** Asynchronously sets `cnt=0`, `acc=0`, `out_valid=0`, `out_data=0`. Mid-window reset discards the partial window. `in_ready` is 1 once `rst` is low.

## Timing
- Throughput is 1 element/cycle with no bubble between windows when `out_ready` is held high.
- Latency: the LAST beat accepted at edge t gives `out_valid=1` with the result after edge t, so the result is visible in cycle t+1.
- A stalled LAST beat completes on the first cycle `out_ready=1`. The old result is taken and the new one loads on the same edge.
- `in_ready` and the `out_ready` to `in_ready` path are combinational. There is no other combinational input-to-output path.
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`.

## Structure
- Shared package `pool_pkg` holds:
  - `POOL_MAX`/`POOL_AVG` constants.
  - Mode enum typedef.
  - clog2 helper used for counter and accumulator widths.
- Sub-module `pool_combine` is purely combinational. It takes (`acc`, element, `MODE`, `SIGNED`) and returns the next `acc`. It is reused by later min-pool and global-pool variants.
- Top-level checks: elaboration error if `MODE=POOL_AVG` and `WINDOW` is not a power of two, or `WINDOW`<2.

## Test plan
- **Signed max, defaults.** Stream elements 0..15 with `out_ready=1` -> one result 15 (`22'h00000F`), `out_valid` one cycle after the 16th beat.
- **Signed max, all negative.** 15 × -1 plus one -3 -> result -1 (`22'h3FFFFF`). Then 16 × -2097152 -> result -2097152.
- **`MODE=POOL_AVG`, `WINDOW=4`.**
  - 3,4,5,-1 -> 2.
  - -1,-2,-2,-2 -> -2 (floor of -1.75).
  - Unsigned build with all inputs `22'h3FFFFF` -> `22'h3FFFFF`.
- **Backpressure.** Hold `out_ready=0` after window 1 -> window 2's first 15 beats are accepted, `in_ready=0` on beat 16. Raise `out_ready` -> result 1 is taken and result 2 loads on the same edge, with no loss.
- **Reset mid-window.** Pulse `rst` after 7 beats -> outputs zero immediately. The next 16 beats produce a result independent of the pre-reset data.
- **`clear`.** Assert `clear` with `in_valid=1` after 5 beats -> that beat is not accepted and a held `out_data` is unchanged. The next window counts from zero.
